// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with write-to-read bypass and a
// per-register busy scoreboard used by issue to track outstanding producers.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32'd32,
    parameter int unsigned ADDR_W   = 32'd5,
    parameter int unsigned NUM_RD   = 32'd2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [(2**ADDR_W)-1:0]     busy_vec,
    output logic [15:0]                wr_count
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [15:0]       wr_count_r;
    logic              wr_ok_s;
    logic              rsv_ok_s;

    // Qualify write and reserve: both are dead while reset is held, and r0 is
    // immune to them when it is hardwired to zero.
    always_comb begin
        wr_ok_s  = 1'b0;
        rsv_ok_s = 1'b0;
        if (rst && wr_en && !(ZERO_REG && (wr_addr == '0))) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
        if (rst && rsv_en && !(ZERO_REG && (rsv_addr == '0))) begin
            rsv_ok_s = 1'b1;
        end else begin
            rsv_ok_s = 1'b0;
        end
    end

    // Next scoreboard image; a reservation beats a retiring write to the same
    // register because the new producer is issued as the old one completes.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int r = 0; r < int'(DEPTH); r++) begin
            if (rsv_ok_s && (rsv_addr == ADDR_W'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (wr_ok_s && (wr_addr == ADDR_W'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Register array storage, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_r[r] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard and saturating accepted-write counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r     <= '0;
            wr_count_r <= 16'h0000;
        end else begin
            busy_r <= busy_nxt_s;
            if (wr_ok_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign busy_vec = busy_r;
    assign wr_count = wr_count_r;

    for (genvar gi = 0; gi < int'(NUM_RD); gi++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = rd_addr[gi*ADDR_W +: ADDR_W];

        // Per-port read resolution: zero register, then forwarded write, then array.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (ZERO_REG && (addr_s == '0)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if (BYPASS && wr_ok_s && (wr_addr == addr_s)) begin
                data_s = wr_data;
                busy_s = 1'b0;
            end else begin
                data_s = mem_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_s;
        assign rd_busy[gi]                  = busy_s;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's 2-read/1-write register file. It generalises data width, depth and read-port count. It adds write-to-read bypass, a per-register scoreboard (busy bits) for the issue stage, and an asynchronous full clear on reset. It sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/reservations
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  write strobe (writeback)
wr_addr  in  ADDR_W  write destination
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve (mark busy) a destination at issue
rsv_addr  in  ADDR_W  register to reserve
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  per-port busy flag of the addressed register, combinational
busy_vec  out  2**ADDR_W  full scoreboard image, registered
wr_count  out  16  number of accepted writes since reset, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0; busy_vec = 0; wr_count = 0.
  - rd_data reflects the cleared array (0) while reset is held.
  - rd_busy = 0.
  - Writes and reservations are ignored while rst=0.
- Write, on the rising clk edge with rst=1:
  - if wr_en and not (ZERO_REG and wr_addr==0): array[wr_addr] <= wr_data, and wr_count increments, saturating at 16'hFFFF.
  - A write to r0 with ZERO_REG=1 is dropped and does not count.
- Read, per port i, combinational:
  - if ZERO_REG and addr==0: data 0.
  - else if BYPASS and wr_en and wr_addr==addr (write not dropped): data = wr_data.
  - else: data = array[addr].
  - With BYPASS=0, the new value is visible from the cycle after the write edge.
- Scoreboard, per register r, on the clock edge:
  - set when rsv_en and rsv_addr==r.
  - clear when wr_en and wr_addr==r.
  - Simultaneous reserve and write to the same r: reserve wins, so busy stays 1 (a new producer is issued in the same cycle as the old one retires).
  - Reserve of an already-busy r: stays busy; no error.
  - Write to a non-busy r: legal and performs the write; busy stays 0.
  - ZERO_REG=1: busy_vec[0] is held at 0.
- rd_busy[i] = busy_vec[addr_i], except:
  - forced 0 when BYPASS=1 and a write to that address is present this cycle (the forwarded data is valid);
  - forced 0 for r0 when ZERO_REG=1.
- Latency:
  - write-to-read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - reserve-to-busy is 1 cycle.
- Multiple read ports may address the same register; each port resolves independently.
- No X on outputs after reset for any address, including out-of-range NUM_RD slots.

Test Plan:
- Reset clears: preload r5=32'hDEAD_BEEF, pulse rst=0 mid-cycle (asynchronous) -> rd_data for r5 = 0 immediately; busy_vec=0; wr_count=0.
- Write/read with bypass: wr_en, r3 <= 32'h1234_5678 while rd_addr port0=3 in the same cycle -> port0 = 32'h1234_5678 that cycle. With BYPASS=0, the same stimulus gives the old value, then the new value next cycle.
- Zero register: write r0 <= 32'hFFFF_FFFF and reserve r0 -> read r0 = 0; busy_vec[0]=0; wr_count unchanged.
- Scoreboard lifecycle: reserve r7 -> busy_vec[7]=1 next cycle, rd_busy=1 on a port reading 7. Write r7=32'hA5 -> busy_vec[7]=0 after the edge, and rd_busy goes low in the write cycle when BYPASS=1.
- Simultaneous reserve and write to r9 -> data updated, busy_vec[9] remains 1. Reserve r9, write r10 in the same cycle -> both effects applied independently.
- NUM_RD=4, all ports reading different and identical addresses (1,1,31,0) after random writes -> each port matches a reference model. wr_count saturates at 16'hFFFF after 65536+ writes (forced count preload allowed).
